alu_internal_seq: RTL and testbench
===================================

# alu_internal_seq

Sequencer sitting directly upstream of the ALU control-field decoders (one per ctrl bit). It accepts one internal-operation request per handshake and expands it into one or two ALU steps. Each step drives the active-low mode strobes (internal MOV, address mode, internal INC/DEC, internal DEC) plus the raw ALU control field, all registered. Pointer-update sequences (post-increment, pre-decrement addressing) therefore reach the decoders as clean, cycle-aligned strobe patterns.

## Interface
- CTRL_W, 4, width of the raw ALU control field passed to the decoders
- clk  in  1  system clock, rising edge
- rst  in  1  reset; synchronous and active-high
- req_valid  in  1  request present
- req_ready  out  1  sequencer accepts a request this cycle
- req_op  in  3  operation code (see Operation)
- req_ctrl  in  CTRL_W  raw ALU control field for the request
- alu_stall  in  1  downstream hold; freezes the current step
- alu_ctrl  out  CTRL_W  control field to the decoders
- internal_mov_n  out  1  low = internal operation
- address_mode_n  out  1  low = address-calculation mode
- internal_inc_dec_n  out  1  low = inc/dec (valid only with internal_mov_n low)
- internal_dec_n  out  1  low = decrement, high = increment
- step_valid  out  1  a step is being presented this cycle
- step_last  out  1  presented step is the final step of its request
- op_err  out  1  request used the reserved opcode (level, held with its step)

## Operation
- Strobe tuple order is {mov_n, addr_n, incdec_n, dec_n}.
  - NORMAL = 1111
  - MOV = 0111
  - INC = 0101
  - DEC = 0100
  - ADDR = 1011
- Opcodes and their step sequences:
  - 0 PASS: NORMAL, ctrl = req_ctrl (1 step)
  - 1 MOV: MOV (1 step)
  - 2 INC: INC (1 step)
  - 3 DEC: DEC (1 step)
  - 4 ADDR: ADDR, ctrl = req_ctrl (1 step)
  - 5 ADDR_POSTINC: ADDR then INC (2 steps)
  - 6 ADDR_PREDEC: DEC then ADDR (2 steps)
  - 7 reserved: NORMAL, ctrl = 0, op_err = 1 (1 step)
- alu_ctrl = req_ctrl on every step of opcodes 0–6. req_ctrl is captured at accept and is not re-sampled.
- FSM states and transitions:
  - IDLE → STEP1 on accept.
  - STEP1 → STEP2 when 2-step and !alu_stall.
  - STEP1/STEP2 (last) → IDLE when !alu_stall and no new accept.
  - Last step → STEP1 of the new request on a same-cycle accept.
- req_ready = !rst && (state == IDLE || (step_last && !alu_stall)).
- Accept = req_valid && req_ready. Inputs must be held stable while valid and not ready.
- Idle outputs:
  - strobes = NORMAL, alu_ctrl = 0
  - step_valid = 0, step_last = 0, op_err = 0
- Invalid strobe combinations (e.g. mov_n = 0 with addr_n = 0) are never produced.

## Timing
- Reset values (rst high at an edge):
  - state = IDLE
  - strobes = 1111, alu_ctrl = 0
  - step_valid = 0, step_last = 0, op_err = 0
  - req_ready = 0 while rst is high; 1 in the first cycle after release.
- All outputs except req_ready are registered.
- Latency: accept at edge N → step 1 visible after edge N; step 2 appears one cycle later if unstalled.
- Throughput:
  - back-to-back 1-step requests: one step per cycle, step_valid stays high.
  - 2-step requests: two cycles each.
- alu_stall high during a step: every output and the FSM hold; req_ready = 0 unless IDLE.
- alu_stall in IDLE does not block accept. The first step then appears and holds until stall drops.
- Consumers treat a step as retired on a cycle with step_valid && !alu_stall.
- rst asserted mid-sequence: the request is abandoned and outputs take idle values after that edge. No partial second step is issued.
- Simultaneous rst and req_valid: rst wins; the request is not accepted.

## Structure
- Package alu_seq_pkg holds:
  - opcode localparams OP_PASS..OP_RSVD
  - strobe tuple constants STB_NORMAL/MOV/INC/DEC/ADDR
  - FSM state encoding
- Sub-module alu_seq_step_rom: combinational {op, step_idx} → {strobes, last, ctrl_sel, err}.
- Top level holds the FSM, capture registers and handshake only.

## Test plan
- Reset, then idle with req_valid = 0 → strobes 1111, alu_ctrl 0, step_valid 0; req_ready 1 after rst release.
- Accept op 2 then op 3 back-to-back, ctrl = 4'h5 → consecutive steps 0101 then 0100, alu_ctrl 5, step_last 1 on both, ready high throughout.
- Accept op 5, ctrl = 4'hA → step 1011/A (step_last 0), then 0101/A (step_last 1); req_ready low during step 1.
- Op 6 with alu_stall high for 3 cycles during step 1 → 0100 held 4 cycles, then 1011 for 1 cycle, then idle.
- Assert rst during step 1 of op 5 → next cycle all idle values, no 0101 step ever appears.
- Op 7, ctrl = 4'hF → one step 1111, alu_ctrl 0, op_err 1, step_last 1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, strobe tuples and FSM encoding for the ALU internal-op sequencer
package alu_seq_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_PASS         = 3'd0;
  localparam logic [OP_W-1:0] OP_MOV          = 3'd1;
  localparam logic [OP_W-1:0] OP_INC          = 3'd2;
  localparam logic [OP_W-1:0] OP_DEC          = 3'd3;
  localparam logic [OP_W-1:0] OP_ADDR         = 3'd4;
  localparam logic [OP_W-1:0] OP_ADDR_POSTINC = 3'd5;
  localparam logic [OP_W-1:0] OP_ADDR_PREDEC  = 3'd6;
  localparam logic [OP_W-1:0] OP_RSVD         = 3'd7;

  // Tuple order {mov_n, addr_n, incdec_n, dec_n}, all active-low
  typedef logic [3:0] strobe_t;

  localparam strobe_t STB_NORMAL = 4'b1111;
  localparam strobe_t STB_MOV    = 4'b0111;
  localparam strobe_t STB_INC    = 4'b0101;
  localparam strobe_t STB_DEC    = 4'b0100;
  localparam strobe_t STB_ADDR   = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STEP1 = 2'd1,
    ST_STEP2 = 2'd2
  } state_t;

endpackage

// File: rtl/alu_internal_seq_if.sv
// rtl/alu_internal_seq_if.sv - request handshake and step outputs of the ALU internal-op sequencer
interface alu_internal_seq_if #(
  parameter int CTRL_W = 4
) ();

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [CTRL_W-1:0] req_ctrl;
  logic              alu_stall;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              internal_mov_n;
  logic              address_mode_n;
  logic              internal_inc_dec_n;
  logic              internal_dec_n;
  logic              step_valid;
  logic              step_last;
  logic              op_err;

  modport master (
    output req_valid, req_op, req_ctrl, alu_stall,
    input  req_ready, alu_ctrl, internal_mov_n, address_mode_n,
           internal_inc_dec_n, internal_dec_n, step_valid, step_last, op_err
  );

  modport slave (
    input  req_valid, req_op, req_ctrl, alu_stall,
    output req_ready, alu_ctrl, internal_mov_n, address_mode_n,
           internal_inc_dec_n, internal_dec_n, step_valid, step_last, op_err
  );

endinterface

// File: rtl/alu_seq_step_rom.sv
// rtl/alu_seq_step_rom.sv - maps {opcode, step index} to the strobe tuple and step attributes
module alu_seq_step_rom
  import alu_seq_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic            step_idx,
  output strobe_t         strobes,
  output logic            last,
  output logic            ctrl_sel,
  output logic            err
);

  always_comb begin
    strobes  = STB_NORMAL;
    last     = 1'b1;
    ctrl_sel = 1'b1;
    err      = 1'b0;
    case (op)
      OP_PASS: strobes = STB_NORMAL;
      OP_MOV:  strobes = STB_MOV;
      OP_INC:  strobes = STB_INC;
      OP_DEC:  strobes = STB_DEC;
      OP_ADDR: strobes = STB_ADDR;
      OP_ADDR_POSTINC: begin
        strobes = step_idx ? STB_INC : STB_ADDR;
        last    = step_idx;
      end
      OP_ADDR_PREDEC: begin
        strobes = step_idx ? STB_ADDR : STB_DEC;
        last    = step_idx;
      end
      default: begin
        // Reserved opcode: harmless NORMAL step with a zeroed control field
        ctrl_sel = 1'b0;
        err      = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_internal_seq.sv
// rtl/alu_internal_seq.sv - expands internal-op requests into one or two registered ALU strobe steps
module alu_internal_seq
  import alu_seq_pkg::*;
#(
  parameter int CTRL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  alu_internal_seq_if.slave  bus
);

  state_t            state_q, state_d;
  logic [OP_W-1:0]   op_q;
  logic [CTRL_W-1:0] ctrl_q;

  strobe_t           stb_q;
  logic [CTRL_W-1:0] alu_ctrl_q;
  logic              valid_q, last_q, err_q;

  logic              ready, accept, load, go_idle;
  logic [OP_W-1:0]   rom_op;
  logic              rom_idx;
  strobe_t           rom_stb;
  logic              rom_last, rom_sel, rom_err;
  logic [CTRL_W-1:0] ctrl_src;

  assign ready  = !rst && (state_q == ST_IDLE || (last_q && !bus.alu_stall));
  assign accept = bus.req_valid && ready;

  alu_seq_step_rom u_rom (
    .op       (rom_op),
    .step_idx (rom_idx),
    .strobes  (rom_stb),
    .last     (rom_last),
    .ctrl_sel (rom_sel),
    .err      (rom_err)
  );

  // A new accept always wins; otherwise an unstalled step advances or retires
  always_comb begin
    state_d  = state_q;
    rom_op   = op_q;
    rom_idx  = 1'b1;
    load     = 1'b0;
    go_idle  = 1'b0;
    ctrl_src = ctrl_q;
    if (accept) begin
      state_d  = ST_STEP1;
      rom_op   = bus.req_op;
      rom_idx  = 1'b0;
      load     = 1'b1;
      ctrl_src = bus.req_ctrl;
    end else if (state_q != ST_IDLE && !bus.alu_stall) begin
      if (state_q == ST_STEP1 && !last_q) begin
        state_d = ST_STEP2;
        load    = 1'b1;
      end else begin
        state_d = ST_IDLE;
        go_idle = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      ctrl_q     <= '0;
      stb_q      <= STB_NORMAL;
      alu_ctrl_q <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= bus.req_op;
        ctrl_q <= bus.req_ctrl;
      end
      if (load) begin
        stb_q      <= rom_stb;
        alu_ctrl_q <= rom_sel ? ctrl_src : '0;
        valid_q    <= 1'b1;
        last_q     <= rom_last;
        err_q      <= rom_err;
      end else if (go_idle) begin
        stb_q      <= STB_NORMAL;
        alu_ctrl_q <= '0;
        valid_q    <= 1'b0;
        last_q     <= 1'b0;
        err_q      <= 1'b0;
      end
    end
  end

  assign bus.req_ready          = ready;
  assign bus.alu_ctrl           = alu_ctrl_q;
  assign bus.internal_mov_n     = stb_q[3];
  assign bus.address_mode_n     = stb_q[2];
  assign bus.internal_inc_dec_n = stb_q[1];
  assign bus.internal_dec_n     = stb_q[0];
  assign bus.step_valid         = valid_q;
  assign bus.step_last          = last_q;
  assign bus.op_err             = err_q;

endmodule

// File: tb/tb_alu_internal_seq.sv
// tb/tb_alu_internal_seq.sv - directed bench with a step-queue model for alu_internal_seq
module tb_alu_internal_seq;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic cmp_en;

  alu_internal_seq_if #(.CTRL_W(4)) bus ();

  alu_internal_seq #(.CTRL_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] stb;
    logic [3:0] ctrl;
    logic       last;
    logic       err;
  } step_t;

  step_t q[$];

  // Observation vector {ready, strobes, ctrl, valid, last, err}
  function automatic logic [11:0] obs();
    return {bus.req_ready, bus.internal_mov_n, bus.address_mode_n, bus.internal_inc_dec_n,
            bus.internal_dec_n, bus.alu_ctrl, bus.step_valid, bus.step_last, bus.op_err};
  endfunction

  function automatic logic model_ready();
    return !rst && (q.size() == 0 || (q[0].last && !bus.alu_stall));
  endfunction

  function automatic logic [11:0] model_obs();
    if (q.size() == 0) return {model_ready(), 4'b1111, 4'h0, 3'b000};
    return {model_ready(), q[0].stb, q[0].ctrl, 1'b1, q[0].last, q[0].err};
  endfunction

  function automatic void expand(logic [2:0] op, logic [3:0] c);
    case (op)
      3'd0: q.push_back('{4'b1111, c, 1'b1, 1'b0});
      3'd1: q.push_back('{4'b0111, c, 1'b1, 1'b0});
      3'd2: q.push_back('{4'b0101, c, 1'b1, 1'b0});
      3'd3: q.push_back('{4'b0100, c, 1'b1, 1'b0});
      3'd4: q.push_back('{4'b1011, c, 1'b1, 1'b0});
      3'd5: begin
        q.push_back('{4'b1011, c, 1'b0, 1'b0});
        q.push_back('{4'b0101, c, 1'b1, 1'b0});
      end
      3'd6: begin
        q.push_back('{4'b0100, c, 1'b0, 1'b0});
        q.push_back('{4'b1011, c, 1'b1, 1'b0});
      end
      default: q.push_back('{4'b1111, 4'h0, 1'b1, 1'b1});
    endcase
  endfunction

  // Model: a step retires on an unstalled edge; an accepted request queues its steps
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      logic acc;
      acc = bus.req_valid && model_ready();
      if (q.size() > 0 && !bus.alu_stall) void'(q.pop_front());
      if (acc) expand(bus.req_op, bus.req_ctrl);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [11:0] e;
      logic [11:0] o;
      e = model_obs();
      o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL cycle t=%0t got=%03h exp=%03h", $time, o, e);
      end
    end
  end

  task automatic chk_lit(input string nm, input logic [11:0] e);
    logic [11:0] o;
    o = obs();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL %s got=%03h exp=%03h", nm, o, e);
    end
  endtask

  logic [11:0] snap;

  task automatic send(input logic [2:0] op, input logic [3:0] c);
    int n;
    @(negedge clk);
    snap = obs();
    #1;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_ctrl  = c;
    n = 0;
    forever begin
      #3;
      if (bus.req_ready) begin
        @(posedge clk);
        break;
      end
      n++;
      if (n > 20) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout op=%0d got=ready0 exp=ready1", op);
        bus.req_valid = 1'b0;
        break;
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drop();
    #1;
    bus.req_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cmp_en = 1'b0;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_ctrl  = 4'h0;
    bus.alu_stall = 1'b0;
    @(posedge clk);
    #1 cmp_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_lit("reset_state", {1'b0, 4'b1111, 4'h0, 3'b000});
    #1 rst = 1'b0;
    @(negedge clk);
    chk_lit("idle_after_release", {1'b1, 4'b1111, 4'h0, 3'b000});

    // Back-to-back single-step INC then DEC
    send(3'd2, 4'h5);
    send(3'd3, 4'h5);
    chk_lit("b2b_inc", snap);
    checks++;
    if (snap !== {1'b1, 4'b0101, 4'h5, 3'b110}) begin
      errors++;
      $display("FAIL b2b_inc_lit got=%03h exp=%03h", snap, {1'b1, 4'b0101, 4'h5, 3'b110});
    end
    @(negedge clk);
    chk_lit("b2b_dec", {1'b1, 4'b0100, 4'h5, 3'b110});
    drop();

    // ADDR_POSTINC
    send(3'd5, 4'hA);
    @(negedge clk);
    chk_lit("postinc_s1", {1'b0, 4'b1011, 4'hA, 3'b100});
    drop();
    @(negedge clk);
    chk_lit("postinc_s2", {1'b1, 4'b0101, 4'hA, 3'b110});
    #1;
    @(negedge clk);
    chk_lit("postinc_idle", {1'b1, 4'b1111, 4'h0, 3'b000});

    // ADDR_PREDEC with a 3-cycle stall on step 1
    send(3'd6, 4'hC);
    @(negedge clk);
    chk_lit("predec_s1_0", {1'b0, 4'b0100, 4'hC, 3'b100});
    #1;
    bus.req_valid = 1'b0;
    bus.alu_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_lit("predec_s1_hold", {1'b0, 4'b0100, 4'hC, 3'b100});
    end
    #1 bus.alu_stall = 1'b0;
    @(negedge clk);
    chk_lit("predec_s2", {1'b1, 4'b1011, 4'hC, 3'b110});
    #1;
    @(negedge clk);
    chk_lit("predec_idle", {1'b1, 4'b1111, 4'h0, 3'b000});

    // Reset during step 1 of ADDR_POSTINC
    send(3'd5, 4'h3);
    @(negedge clk);
    chk_lit("rst_mid_s1", {1'b0, 4'b1011, 4'h3, 3'b100});
    #1;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk_lit("rst_mid_idle", {1'b0, 4'b1111, 4'h0, 3'b000});
    #1 rst = 1'b0;
    @(negedge clk);
    chk_lit("rst_mid_after", {1'b1, 4'b1111, 4'h0, 3'b000});

    // Reset and request together: reset wins
    #1;
    rst = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd2;
    bus.req_ctrl  = 4'h1;
    @(negedge clk);
    chk_lit("rst_vs_req", {1'b0, 4'b1111, 4'h0, 3'b000});
    #1;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk_lit("rst_vs_req_after", {1'b1, 4'b1111, 4'h0, 3'b000});

    // Reserved opcode
    send(3'd7, 4'hF);
    @(negedge clk);
    chk_lit("rsvd", {1'b1, 4'b1111, 4'h0, 3'b111});
    drop();
    @(negedge clk);
    chk_lit("rsvd_idle", {1'b1, 4'b1111, 4'h0, 3'b000});

    // Accept while stalled in IDLE: step holds until stall drops
    #1 bus.alu_stall = 1'b1;
    send(3'd1, 4'h6);
    @(negedge clk);
    chk_lit("idle_stall_s1", {1'b0, 4'b0111, 4'h6, 3'b110});
    drop();
    @(negedge clk);
    chk_lit("idle_stall_hold", {1'b0, 4'b0111, 4'h6, 3'b110});
    #1 bus.alu_stall = 1'b0;
    @(negedge clk);
    chk_lit("idle_stall_done", {1'b1, 4'b1111, 4'h0, 3'b000});

    // Mixed stream, checked by the model
    send(3'd0, 4'h9);
    send(3'd4, 4'h7);
    send(3'd5, 4'h2);
    send(3'd1, 4'h2);
    send(3'd6, 4'hE);
    send(3'd3, 4'h8);
    drop();
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
